// File: rtl/fx3_gpif_responder.sv
// Fx3 side of the 23-bit GPO/INTR -> GPI/ACK link.
// Captures GPO on INTR fall, answers on GPI with a low ACK pulse.
module fx3_gpif_responder #(
  parameter int RESP_DELAY  = 16,
  parameter int ACK_WIDTH   = 4,
  parameter int BOOT_CYCLES = 1000
) (
  input  logic        clk_40_mhz,
  input  logic        reset,
  input  logic        fx3_rst,
  input  logic [22:0] GPO,
  input  logic        INTR,
  output logic [22:0] GPI,
  output logic        ACK,
  output logic        Fx3_ready,
  input  logic        inject_err,
  input  logic [22:0] err_mask,
  output logic [7:0]  xfer_count,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_ACK_LO
  } state_t;

  localparam logic [15:0] BOOT_LAST = 16'(BOOT_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(RESP_DELAY - 1);
  localparam logic [15:0] ACK_LAST  = 16'(ACK_WIDTH - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [22:0] data_q, data_d;
  logic [22:0] gpi_q, gpi_d;
  logic        ack_q, ack_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  xfer_q, xfer_d;
  logic        ovr_q, ovr_d;
  logic        s1_q, s2_q, s3_q;
  logic        fall;
  logic        boot_done;
  logic        wait_done;
  logic        ack_done;
  logic        busy;

  assign fall      = !s2_q && s3_q;
  assign boot_done = (state_q == S_BOOT) && (cnt_q == BOOT_LAST);
  assign wait_done = (state_q == S_WAIT) && (cnt_q == WAIT_LAST);
  assign ack_done  = (state_q == S_ACK_LO) && (cnt_q == ACK_LAST);
  assign busy      = (state_q == S_WAIT) || (state_q == S_SETUP) ||
                     (state_q == S_ACK_LO);

  // INTR is asynchronous: two-flop synchronizer plus history flop.
  always_ff @(posedge clk_40_mhz) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= INTR;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // State register.
  always_ff @(posedge clk_40_mhz) begin
    if (reset) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; fx3_rst forces BOOT from anywhere.
  always_comb begin
    state_d = state_q;
    if (fx3_rst) begin
      state_d = S_BOOT;
    end else begin
      unique case (state_q)
        S_BOOT:   if (boot_done) state_d = S_IDLE;
        S_IDLE:   if (fall) state_d = S_WAIT;
        S_WAIT:   if (wait_done) state_d = S_SETUP;
        S_SETUP:  state_d = S_ACK_LO;
        S_ACK_LO: if (ack_done) state_d = S_IDLE;
        default:  state_d = S_BOOT;
      endcase
    end
  end

  // Next values of the counter and the registered outputs.
  always_comb begin
    cnt_d  = cnt_q + 16'd1;
    data_d = data_q;
    gpi_d  = gpi_q;
    ack_d  = ack_q;
    rdy_d  = (state_d != S_BOOT);
    xfer_d = xfer_q;
    ovr_d  = ovr_q;
    if (fx3_rst || state_d != state_q || state_q == S_IDLE) begin
      cnt_d = 16'd0;
    end
    if (fx3_rst) begin
      gpi_d = 23'd0;
      ack_d = 1'b1;
    end else begin
      if (state_q == S_IDLE && fall) begin
        data_d = GPO ^ (inject_err ? err_mask : 23'd0);
      end
      if (busy && fall) begin
        ovr_d = 1'b1;
      end
      if (wait_done) begin
        gpi_d = data_q;
      end
      if (state_q == S_SETUP) begin
        ack_d = 1'b0;
      end
      if (ack_done) begin
        ack_d  = 1'b1;
        xfer_d = xfer_q + 8'd1;
      end
    end
  end

  // Counter, captured word and output registers.
  always_ff @(posedge clk_40_mhz) begin
    if (reset) begin
      cnt_q  <= 16'd0;
      data_q <= 23'd0;
      gpi_q  <= 23'd0;
      ack_q  <= 1'b1;
      rdy_q  <= 1'b0;
      xfer_q <= 8'd0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      gpi_q  <= gpi_d;
      ack_q  <= ack_d;
      rdy_q  <= rdy_d;
      xfer_q <= xfer_d;
      ovr_q  <= ovr_d;
    end
  end

  assign GPI        = gpi_q;
  assign ACK        = ack_q;
  assign Fx3_ready  = rdy_q;
  assign xfer_count = xfer_q;
  assign overrun    = ovr_q;

endmodule
